// File: rtl/dcache_pkg.sv
// Shared types and sizing for the store-buffer-facing D-cache responder.
// Provides the FSM state enum, the captured store bundle and default geometry.
package dcache_pkg;

    localparam int DC_ADDR_W  = 32;
    localparam int DC_DATA_W  = 32;
    localparam int DC_SEL_W   = DC_DATA_W / 8;
    localparam int DC_LINES   = 16;
    localparam int DC_INDEX_W = $clog2(DC_LINES);
    localparam int DC_TAG_W   = DC_ADDR_W - DC_INDEX_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MEM_WR,
        ACK
    } dcache_state_e;

    typedef struct packed {
        logic [DC_ADDR_W-1:0] addr;
        logic [DC_DATA_W-1:0] wdata;
        logic [DC_SEL_W-1:0]  sel_byte;
    } stb_req_t;

    function automatic logic full_word(input logic [DC_SEL_W-1:0] sel);
        return &sel;
    endfunction

endpackage

// File: rtl/dcache_word_array.sv
// Direct-mapped word storage: valid/tag/data with flush and async reset.
// Ports: rd lookup (comb hit/data), probe hit on the write index, one byte-masked write.
module dcache_word_array
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH     = DC_DATA_W,
    parameter int BYTE_SEL_WIDTH = DC_SEL_W,
    parameter int NUM_LINES      = DC_LINES,
    parameter int INDEX_W        = $clog2(NUM_LINES),
    parameter int TAG_W          = DC_TAG_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_flush,
    input  logic [INDEX_W-1:0]        i_rd_idx,
    input  logic [TAG_W-1:0]          i_rd_tag,
    output logic                      o_rd_hit,
    output logic [DATA_WIDTH-1:0]     o_rd_data,
    output logic                      o_pr_hit,
    input  logic                      i_wr_en,
    input  logic                      i_wr_alloc,
    input  logic [INDEX_W-1:0]        i_wr_idx,
    input  logic [TAG_W-1:0]          i_wr_tag,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic [BYTE_SEL_WIDTH-1:0] i_wr_sel
);

    logic [NUM_LINES-1:0]  r_valid;
    logic [TAG_W-1:0]      r_tag  [NUM_LINES];
    logic [DATA_WIDTH-1:0] r_data [NUM_LINES];
    logic [DATA_WIDTH-1:0] w_merged;

    assign o_rd_hit  = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_data = o_rd_hit ? r_data[i_rd_idx] : '0;
    assign o_pr_hit  = r_valid[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag);

    // Allocation always carries a full word, so one merge path serves both.
    always_comb begin
        w_merged = r_data[i_wr_idx];
        for (int i = 0; i < BYTE_SEL_WIDTH; i++) begin
            if (i_wr_sel[i]) begin
                w_merged[8*i +: 8] = i_wr_data[8*i +: 8];
            end
        end
    end

    // Flush wins over a same-edge allocate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_wr_en && i_wr_alloc) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_data[i_wr_idx] <= w_merged;
            if (i_wr_alloc) begin
                r_tag[i_wr_idx] <= i_wr_tag;
            end
        end
    end

endmodule

// File: rtl/dcache_stb_responder.sv
// Store-buffer drain responder: one store at a time, cache update, write-through, ack.
// Ports: stb2dcache_* request, dcache2stb_ack, dcache2mem_*/mem2dcache_ack, LSU lookup, flush.
module dcache_stb_responder
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH     = DC_ADDR_W,
    parameter int DATA_WIDTH     = DC_DATA_W,
    parameter int BYTE_SEL_WIDTH = DC_SEL_W,
    parameter int NUM_LINES      = DC_LINES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stb2dcache_req,
    input  logic                      stb2dcache_w_en,
    input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    output logic                      dcache2stb_ack,
    output logic                      dcache2mem_req,
    output logic [ADDR_WIDTH-1:0]     dcache2mem_addr,
    output logic [DATA_WIDTH-1:0]     dcache2mem_wdata,
    output logic [BYTE_SEL_WIDTH-1:0] dcache2mem_sel_byte,
    input  logic                      mem2dcache_ack,
    input  logic [ADDR_WIDTH-1:0]     lsu2dcache_rd_addr,
    output logic [DATA_WIDTH-1:0]     dcache2lsu_rdata,
    output logic                      dcache2lsu_hit,
    input  logic                      dcache_flush
);

    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = ADDR_WIDTH - IW - 2;

    dcache_state_e r_state;
    dcache_state_e w_next;
    stb_req_t      r_req;

    logic          w_take;
    logic          w_pr_hit;
    logic          w_wr_en;
    logic          w_wr_alloc;
    logic          w_sel_none;
    logic [IW-1:0] w_cap_idx;
    logic [TW-1:0] w_cap_tag;
    logic          w_unused;

    assign w_take     = stb2dcache_req && stb2dcache_w_en;
    assign w_sel_none = (r_req.sel_byte == '0);
    assign w_cap_idx  = r_req.addr[IW+1:2];
    assign w_cap_tag  = r_req.addr[ADDR_WIDTH-1:IW+2];
    assign w_unused   = &{1'b0, lsu2dcache_rd_addr[1:0], r_req.addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req <= '0;
        end else if (r_state == IDLE && w_take) begin
            r_req <= '{addr:     stb2dcache_addr,
                       wdata:    stb2dcache_wdata,
                       sel_byte: stb2dcache_sel_byte};
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_take) w_next = LOOKUP;
            LOOKUP:  w_next = w_sel_none ? ACK : MEM_WR;
            MEM_WR:  if (mem2dcache_ack) w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Hit merges bytes; a full-word miss allocates; partial misses bypass.
    always_comb begin
        dcache2mem_req = 1'b0;
        dcache2stb_ack = 1'b0;
        w_wr_en        = 1'b0;
        w_wr_alloc     = 1'b0;
        unique case (r_state)
            LOOKUP: begin
                if (!w_sel_none) begin
                    if (w_pr_hit) begin
                        w_wr_en = 1'b1;
                    end else if (full_word(r_req.sel_byte)) begin
                        w_wr_en    = 1'b1;
                        w_wr_alloc = 1'b1;
                    end
                end
            end
            MEM_WR:  dcache2mem_req = 1'b1;
            ACK:     dcache2stb_ack = 1'b1;
            default: ;
        endcase
    end

    assign dcache2mem_addr     = {r_req.addr[ADDR_WIDTH-1:2], 2'b00};
    assign dcache2mem_wdata    = r_req.wdata;
    assign dcache2mem_sel_byte = r_req.sel_byte;

    dcache_word_array #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BYTE_SEL_WIDTH (BYTE_SEL_WIDTH),
        .NUM_LINES      (NUM_LINES),
        .INDEX_W        (IW),
        .TAG_W          (TW)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (dcache_flush),
        .i_rd_idx   (lsu2dcache_rd_addr[IW+1:2]),
        .i_rd_tag   (lsu2dcache_rd_addr[ADDR_WIDTH-1:IW+2]),
        .o_rd_hit   (dcache2lsu_hit),
        .o_rd_data  (dcache2lsu_rdata),
        .o_pr_hit   (w_pr_hit),
        .i_wr_en    (w_wr_en),
        .i_wr_alloc (w_wr_alloc),
        .i_wr_idx   (w_cap_idx),
        .i_wr_tag   (w_cap_tag),
        .i_wr_data  (r_req.wdata),
        .i_wr_sel   (r_req.sel_byte)
    );

endmodule
